// File: rtl/csa_accumulator.sv
// Streaming accumulator built on a BLOCK-grouped carry-skip adder, with a sticky overflow flag and a saturating beat count.
// Optional macro ACC_SATURATE_EN clamps the sum to all-ones after the first carry-out of a group.
module csa_accumulator #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [7:0]       out_count
);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q;

  logic [WIDTH-1:0] sum_w;
  logic             add_cout;
  logic             rip_c, grp_p, grp_cin;

  // Each group ripples internally; a fully-propagating group forwards its carry-in straight through.
  always_comb begin
    sum_w   = '0;
    rip_c   = 1'b0;
    grp_p   = 1'b1;
    grp_cin = 1'b0;
    for (int g = 0; g < WIDTH / BLOCK; g++) begin
      rip_c = grp_cin;
      grp_p = 1'b1;
      for (int b = 0; b < BLOCK; b++) begin
        sum_w[g*BLOCK+b] = acc_q[g*BLOCK+b] ^ in_data[g*BLOCK+b] ^ rip_c;
        rip_c = (acc_q[g*BLOCK+b] & in_data[g*BLOCK+b]) |
                ((acc_q[g*BLOCK+b] ^ in_data[g*BLOCK+b]) & rip_c);
        grp_p = grp_p & (acc_q[g*BLOCK+b] ^ in_data[g*BLOCK+b]);
      end
      grp_cin = grp_p ? grp_cin : rip_c;
    end
    add_cout = grp_cin;
  end

  always_comb begin
    ovf_d = ovf_q | add_cout;
    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef ACC_SATURATE_EN
    acc_d = (ovf_q || add_cout) ? {WIDTH{1'b1}} : sum_w;
`else
    acc_d = sum_w;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid && in_ready_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (in_last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready && out_valid_q) begin
            state_q     <= ACC;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_cout  = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed-vector bench for csa_accumulator; expected values are hand-computed constants.
// Build with +define+ACC_SATURATE_EN to exercise the clamping variant.
module tb_csa_accumulator;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [7:0]       out_count;

  int checks = 0;
  int failures = 0;

  csa_accumulator #(.WIDTH(WIDTH), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Present one beat for exactly one rising edge, then idle the input.
  task automatic send_beat(input logic [WIDTH-1:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0055;
    in_last  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_sum !== 32'h0 || out_count !== 8'd0 || out_cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_regs got sum=%h cnt=%0d cout=%b want sum=0 cnt=0 cout=0",
               out_sum, out_count, out_cout);
    end
  endtask

  task automatic test_carry_chain();
    send_beat(32'h0000_FFFF, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL early_valid got=%b want=0", out_valid);
    end
    send_beat(32'h0000_0001, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_flags got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 32'h0001_0000 || out_cout !== 1'b0 || out_count !== 8'd2) begin
      failures++;
      $display("[TB] FAIL carry_chain got sum=%h cout=%b cnt=%0d want sum=00010000 cout=0 cnt=2",
               out_sum, out_cout, out_count);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] want_sum;
`ifdef ACC_SATURATE_EN
    want_sum = 32'hFFFF_FFFF;
`else
    want_sum = 32'h0000_0000;
`endif
    send_beat(32'hAAAA_AAAA, 1'b0);
    send_beat(32'h5555_5555, 1'b0);
    checks++;
    if (out_sum !== 32'hFFFF_FFFF || out_cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_partial got sum=%h cout=%b want sum=ffffffff cout=0", out_sum, out_cout);
    end
    send_beat(32'h0000_0001, 1'b1);
    checks++;
    if (out_sum !== want_sum || out_cout !== 1'b1 || out_count !== 8'd3) begin
      failures++;
      $display("[TB] FAIL ovf_group got sum=%h cout=%b cnt=%0d want sum=%h cout=1 cnt=3",
               out_sum, out_cout, out_count, want_sum);
    end
    release_result();

    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b1);
`ifdef ACC_SATURATE_EN
    want_sum = 32'hFFFF_FFFF;
`else
    want_sum = 32'hFFFF_FFFE;
`endif
    checks++;
    if (out_sum !== want_sum || out_cout !== 1'b1 || out_count !== 8'd2) begin
      failures++;
      $display("[TB] FAIL all_ones got sum=%h cout=%b cnt=%0d want sum=%h cout=1 cnt=2",
               out_sum, out_cout, out_count, want_sum);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    send_beat(32'h0000_0005, 1'b0);
    send_beat(32'h0000_0003, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h0000_0100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h8 ||
          out_count !== 8'd2 || out_cout !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_%0d got valid=%b ready=%b sum=%h cnt=%0d cout=%b want 1 0 00000008 2 0",
                 i, out_valid, in_ready, out_sum, out_count, out_cout);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'h0 || out_count !== 8'd0) begin
      failures++;
      $display("[TB] FAIL hold_release got ready=%b valid=%b sum=%h cnt=%0d want 1 0 0 0",
               in_ready, out_valid, out_sum, out_count);
    end
    send_beat(32'h0000_0007, 1'b1);
    checks++;
    if (out_sum !== 32'h7 || out_count !== 8'd1 || out_cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_hold got sum=%h cnt=%0d cout=%b want sum=00000007 cnt=1 cout=0",
               out_sum, out_count, out_cout);
    end
    release_result();
  endtask

  task automatic test_reset_midgroup();
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b0);
    send_beat(32'h3, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0040;
    in_last  = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_sum !== 32'h0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset got sum=%h cnt=%0d ready=%b want 0 0 1", out_sum, out_count, in_ready);
    end
    send_beat(32'h1234_5678, 1'b1);
    checks++;
    if (out_sum !== 32'h1234_5678 || out_count !== 8'd1 || out_cout !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_beat got sum=%h cnt=%0d cout=%b valid=%b want 12345678 1 0 1",
               out_sum, out_count, out_cout, out_valid);
    end
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'h0) begin
      failures++;
      $display("[TB] FAIL done_reset got valid=%b ready=%b sum=%h want 0 1 0", out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_count_saturation();
    for (int i = 0; i < 300; i++) begin
      send_beat(32'h1, (i == 299));
      if (i == 254) begin
        checks++;
        if (out_count !== 8'd255) begin
          failures++; $display("[TB] FAIL count_255 got=%0d want=255", out_count);
        end
      end
    end
    checks++;
    if (out_count !== 8'd255 || out_sum !== 32'h0000_012C || out_cout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL count_sat got cnt=%0d sum=%h cout=%b want 255 0000012c 0",
               out_count, out_sum, out_cout);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    send_beat(32'h0FFF_FFFF, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    checks++;
    if (out_sum !== 32'h1000_0000 || out_cout !== 1'b0 || out_count !== 8'd2) begin
      failures++;
      $display("[TB] FAIL skip_chain got sum=%h cout=%b cnt=%0d want 10000000 0 2",
               out_sum, out_cout, out_count);
    end
    release_result();
    send_beat(32'h1234_5678, 1'b0);
    send_beat(32'h8765_4321, 1'b1);
    checks++;
    if (out_sum !== 32'h9999_9999 || out_cout !== 1'b0 || out_count !== 8'd2) begin
      failures++;
      $display("[TB] FAIL b2b_group got sum=%h cout=%b cnt=%0d want 99999999 0 2",
               out_sum, out_cout, out_count);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_backpressure();
    test_reset_midgroup();
    test_count_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and accumulator width in bits.
REQ-002 The block SHALL have parameter BLOCK, default 4, giving the carry-skip group size; WIDTH SHALL be a multiple of BLOCK.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: operand beat present.
REQ-006 Port in_data, input, WIDTH bits: operand to add.
REQ-007 Port in_last, input, 1 bit: marks the final operand of a group; sampled only with an accepted beat.
REQ-008 Port in_ready, output, 1 bit: block can accept a beat.
REQ-009 Port out_valid, output, 1 bit: group result available.
REQ-010 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 Port out_sum, output, WIDTH bits: accumulated sum.
REQ-012 Port out_cout, output, 1 bit: sticky carry-out (overflow) of the group.
REQ-013 Port out_count, output, 8 bits: number of beats accepted in the group, saturating at 255.

Function
REQ-014 The FSM SHALL have exactly two states: ACC and DONE.
REQ-015 In ACC: in_ready=1 and out_valid=0. In DONE: in_ready=0 and out_valid=1.
REQ-016 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 On accept: acc <= acc + in_data (carry-in 0) through a BLOCK-grouped carry-skip adder; ovf <= ovf | carry-out; count <= min(count+1, 255).
REQ-018 On accept with in_last=1, the state SHALL go to DONE; out_valid SHALL assert in the next cycle, one cycle after the last beat.
REQ-019 In DONE: out_sum, out_cout and out_count SHALL hold stable until out_valid=1 and out_ready=1 on a rising edge.
REQ-020 On the output handshake: state returns to ACC; acc, ovf and count clear to 0; in_ready asserts in the next cycle.
REQ-021 in_valid in DONE SHALL be ignored, with no state change.
REQ-022 A single-beat group (in_last on the first beat) SHALL give out_sum=in_data, out_count=1 and out_cout=0.
REQ-023 out_sum, out_cout and out_count SHALL be driven directly from registers, with no combinational path from the inputs.
REQ-024 Once out_count reaches 255 it SHALL hold at 255, while accumulation continues.

Reset
REQ-025 When rst_n=0 at a rising edge: state=ACC, acc=0, ovf=0, count=0, out_valid=0 and in_ready=1, taking effect from the next cycle.
REQ-026 Reset SHALL take priority over any simultaneous handshake; a reset in mid-group or in DONE SHALL discard the partial or pending result.
REQ-027 No beat SHALL be accepted on an edge where rst_n=0.

Configuration
REQ-028 Macro ACC_SATURATE_EN: when defined, a carry-out on accept SHALL set acc to all-ones and ovf to 1; acc SHALL then stay all-ones for the rest of the group.
REQ-029 Without ACC_SATURATE_EN, acc SHALL wrap modulo 2^WIDTH and only ovf records the overflow.

Verification
REQ-030 Reset, then beats 0x0000FFFF and 0x00000001 (last) -> out_sum=0x00010000, out_cout=0, out_count=2, out_valid 1 cycle after the last beat.
REQ-031 Beats 0xAAAAAAAA, 0x55555555, 0x00000001 (last) -> default build: out_sum=0x00000000, out_cout=1, out_count=3; ACC_SATURATE_EN build: out_sum=0xFFFFFFFF, out_cout=1.
REQ-032 Result held with out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no beat accepted; then out_ready=1 -> ACC next cycle, and the next group starts from 0.
REQ-033 Beats 0xFFFFFFFF, 0xFFFFFFFF (last) -> default build: out_sum=0xFFFFFFFE, out_cout=1.
REQ-034 rst_n=0 for 1 cycle after 3 non-last beats -> next group with a single beat 0x12345678 (last) gives out_sum=0x12345678, out_count=1, out_cout=0.
REQ-035 300 beats of 0x00000001, the last flagged in_last -> out_count=255, out_sum=0x0000012C, out_cout=0.
